// File: rtl/rv32_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv32_mem_arbiter: shares one variable-latency memory bus between fetch and |
// | load/store ports. Option: RV32_MEM_ARB_ROUND_ROBIN_EN. Revision: 1.0       |
// +----------------------------------------------------------------------------+
module rv32_mem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_read_en_in,
  input  logic [31:0] instr_address_in,
  output logic        instr_ready_out,
  output logic [31:0] instr_read_value_out,
  input  logic        data_read_en_in,
  input  logic        data_write_en_in,
  input  logic [31:0] data_address_in,
  input  logic [31:0] data_write_value_in,
  input  logic [3:0]  data_write_mask_in,
  output logic        data_ready_out,
  output logic [31:0] data_read_value_out,
  output logic        mem_valid_out,
  output logic        mem_write_en_out,
  output logic [31:0] mem_address_out,
  output logic [31:0] mem_write_value_out,
  output logic [3:0]  mem_write_mask_out,
  input  logic        mem_ready_in,
  input  logic [31:0] mem_read_value_in
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state;
  logic        owner_data;
  logic        data_req;
  logic        any_req;
  logic        grant_data;
  logic        grant_write;
  logic [31:0] grant_address;

  assign data_req = data_read_en_in | data_write_en_in;
  assign any_req  = data_req | instr_read_en_in;

`ifdef RV32_MEM_ARB_ROUND_ROBIN_EN
  logic last_data;

  // On a conflict the port that did not win last time gets the bus.
  assign grant_data = data_req & (~instr_read_en_in | ~last_data);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_data <= 1'b0;
    end else if (state == ST_IDLE && any_req) begin
      last_data <= grant_data;
    end
  end
`else
  assign grant_data = data_req;
`endif

  assign grant_write   = grant_data & data_write_en_in;
  assign grant_address = grant_data ? data_address_in : instr_address_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= ST_IDLE;
      owner_data           <= 1'b0;
      instr_ready_out      <= 1'b0;
      instr_read_value_out <= 32'd0;
      data_ready_out       <= 1'b0;
      data_read_value_out  <= 32'd0;
      mem_valid_out        <= 1'b0;
      mem_write_en_out     <= 1'b0;
      mem_address_out      <= 32'd0;
      mem_write_value_out  <= 32'd0;
      mem_write_mask_out   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner_data          <= grant_data;
            mem_valid_out       <= 1'b1;
            mem_write_en_out    <= grant_write;
            mem_address_out     <= {grant_address[31:2], 2'b00};
            mem_write_value_out <= grant_write ? data_write_value_in : 32'd0;
            mem_write_mask_out  <= grant_write ? data_write_mask_in : 4'd0;
            state               <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ready_in) begin
            mem_valid_out <= 1'b0;
            if (owner_data) begin
              data_ready_out <= 1'b1;
              if (!mem_write_en_out) begin
                data_read_value_out <= mem_read_value_in;
              end
            end else begin
              instr_ready_out      <= 1'b1;
              instr_read_value_out <= mem_read_value_in;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Requests are not sampled here so a still-held request is not re-granted.
          instr_ready_out <= 1'b0;
          data_ready_out  <= 1'b0;
          state           <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rv32_mem_arbiter: transaction-level model and directed vectors for the  |
// | memory arbiter. Revision: 1.0                                              |
// +----------------------------------------------------------------------------+
module tb_rv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_read_en_in = 1'b0;
  logic [31:0] instr_address_in = 32'd0;
  logic        instr_ready_out;
  logic [31:0] instr_read_value_out;
  logic        data_read_en_in = 1'b0;
  logic        data_write_en_in = 1'b0;
  logic [31:0] data_address_in = 32'd0;
  logic [31:0] data_write_value_in = 32'd0;
  logic [3:0]  data_write_mask_in = 4'd0;
  logic        data_ready_out;
  logic [31:0] data_read_value_out;
  logic        mem_valid_out;
  logic        mem_write_en_out;
  logic [31:0] mem_address_out;
  logic [31:0] mem_write_value_out;
  logic [3:0]  mem_write_mask_out;
  logic        mem_ready_in = 1'b0;
  logic [31:0] mem_read_value_in = 32'd0;

  rv32_mem_arbiter dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .instr_read_en_in    (instr_read_en_in),
    .instr_address_in    (instr_address_in),
    .instr_ready_out     (instr_ready_out),
    .instr_read_value_out(instr_read_value_out),
    .data_read_en_in     (data_read_en_in),
    .data_write_en_in    (data_write_en_in),
    .data_address_in     (data_address_in),
    .data_write_value_in (data_write_value_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_ready_out      (data_ready_out),
    .data_read_value_out (data_read_value_out),
    .mem_valid_out       (mem_valid_out),
    .mem_write_en_out    (mem_write_en_out),
    .mem_address_out     (mem_address_out),
    .mem_write_value_out (mem_write_value_out),
    .mem_write_mask_out  (mem_write_mask_out),
    .mem_ready_in        (mem_ready_in),
    .mem_read_value_in   (mem_read_value_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=ready at %0t", name, $time);
  endtask

  // Memory responder: answers after lat wait cycles, data is a function of address.
  int lat = 0;
  int cnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mem_valid_out && reset_n) begin
        if (cnt >= lat) begin
          mem_ready_in      = 1'b1;
          mem_read_value_in = mem_address_out ^ 32'hDEADBFEB;
          cnt               = 0;
        end else begin
          mem_ready_in = 1'b0;
          cnt++;
        end
      end else begin
        mem_ready_in = 1'b0;
        cnt          = 0;
      end
    end
  end

  // Transaction-level model: one bus transaction at a time, a grant is taken
  // from pending requests whenever the bus is free and no completion is showing.
  bit          m_out = 0;
  bit          m_owner = 0;
  bit          m_we = 0;
  logic [31:0] m_addr = 0, m_wv = 0, m_iv = 0, m_dv = 0;
  logic [3:0]  m_mask = 0;
  int          m_pulse = 0;
  int          np;
  bit          m_last = 0;
  bit          gd, dreq;
  int          grants[$];
  int          vrun = 0, last_vrun = 0;
  logic [31:0] act_addr = 0;
  logic [3:0]  act_mask = 0;
  logic        act_we = 0;
  logic        prev_valid = 0;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_out = 0; m_owner = 0; m_we = 0; m_addr = 0; m_wv = 0; m_mask = 0;
        m_iv = 0; m_dv = 0; m_pulse = 0; m_last = 0; vrun = 0;
      end
      chk("mem_valid", {31'd0, mem_valid_out}, {31'd0, m_out});
      chk("instr_ready", {31'd0, instr_ready_out}, {31'd0, m_pulse == 1});
      chk("data_ready", {31'd0, data_ready_out}, {31'd0, m_pulse == 2});
      chk("instr_value", instr_read_value_out, m_iv);
      chk("data_value", data_read_value_out, m_dv);
      if (m_out) begin
        chk("mem_addr", mem_address_out, m_addr);
        chk("mem_we", {31'd0, mem_write_en_out}, {31'd0, m_we});
        chk("mem_wval", mem_write_value_out, m_wv);
        chk("mem_mask", {28'd0, mem_write_mask_out}, {28'd0, m_mask});
      end
      if (mem_valid_out && !prev_valid) begin
        act_addr = mem_address_out;
        act_mask = mem_write_mask_out;
        act_we   = mem_write_en_out;
      end
      prev_valid = mem_valid_out;
      if (mem_valid_out) vrun++;
      else if (vrun > 0) begin
        last_vrun = vrun;
        vrun      = 0;
      end
      if (reset_n) begin
        dreq = data_read_en_in || data_write_en_in;
        np   = 0;
        if (m_out) begin
          if (mem_ready_in) begin
            m_out = 0;
            np    = m_owner ? 2 : 1;
            if (!m_we) begin
              if (m_owner) m_dv = mem_read_value_in;
              else         m_iv = mem_read_value_in;
            end
          end
        end else if (m_pulse == 0 && (dreq || instr_read_en_in)) begin
          if (!instr_read_en_in)  gd = 1;
          else if (!dreq)         gd = 0;
          else begin
`ifdef RV32_MEM_ARB_ROUND_ROBIN_EN
            gd = !m_last;
`else
            gd = 1;
`endif
          end
          m_last  = gd;
          m_owner = gd;
          m_addr  = (gd ? data_address_in : instr_address_in) & 32'hFFFF_FFFC;
          m_we    = gd && data_write_en_in;
          m_wv    = m_we ? data_write_value_in : 32'd0;
          m_mask  = m_we ? data_write_mask_in : 4'd0;
          m_out   = 1;
          grants.push_back(gd ? 2 : 1);
        end
        m_pulse = np;
      end
    end
  end

  // Requester tasks start and end at posedge+2.
  task automatic fetch(input logic [31:0] a, output int cyc);
    bit done;
    instr_address_in = a;
    instr_read_en_in = 1'b1;
    cyc  = 0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (instr_ready_out) done = 1;
      else begin
        @(posedge clk); #2;
        cyc++;
      end
    end
    if (!done) timeout("fetch_timeout");
    @(posedge clk); #2;
    instr_read_en_in = 1'b0;
  endtask

  task automatic data(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] v, input logic [3:0] m);
    bit done;
    data_address_in     = a;
    data_write_value_in = v;
    data_write_mask_in  = m;
    data_read_en_in     = rd;
    data_write_en_in    = wr;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (data_ready_out) done = 1;
      else begin
        @(posedge clk); #2;
      end
    end
    if (!done) timeout("data_timeout");
    @(posedge clk); #2;
    data_read_en_in  = 1'b0;
    data_write_en_in = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    grants.delete();
  endtask

  int l;
  int exp_b2b[8];
  bit seen;

  initial begin
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Single zero-wait fetch.
    do_reset();
    lat = 0;
    fetch(32'h0000_0106, l);
    chk("fetch_latency", l, 32'd2);
    chk("fetch_addr", act_addr, 32'h0000_0104);
    chk("fetch_mask", {28'd0, act_mask}, 32'd0);
    chk("fetch_value", instr_read_value_out, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1 chk("fetch_value_held", instr_read_value_out, 32'hDEADBEEF);
    #1;

    // Load, then a store with three wait cycles.
    lat = 1;
    data(1, 0, 32'h200, 32'd0, 4'd0);
    chk("load_value", data_read_value_out, 32'hDEADBDEB);
    lat = 3;
    data(0, 1, 32'h40, 32'h12345678, 4'b0011);
    chk("store_valid_cycles", last_vrun, 32'd4);
    chk("store_addr", act_addr, 32'h40);
    chk("store_mask", {28'd0, act_mask}, 32'h3);
    chk("store_we", {31'd0, act_we}, 32'd1);
    chk("store_keeps_load_value", data_read_value_out, 32'hDEADBDEB);

    // Simultaneous fetch and load.
    do_reset();
    lat = 0;
    fork
      fetch(32'h300, l);
      data(1, 0, 32'h500, 32'd0, 4'd0);
    join
    chk("conflict_count", grants.size(), 32'd2);
    if (grants.size() == 2) begin
      chk("conflict_first", grants[0], 32'd2);
      chk("conflict_second", grants[1], 32'd1);
    end

    // Back-to-back data with fetch also pending.
    do_reset();
`ifdef RV32_MEM_ARB_ROUND_ROBIN_EN
    exp_b2b = '{2, 1, 2, 1, 2, 1, 2, 1};
`else
    exp_b2b = '{2, 2, 2, 2, 1, 1, 1, 1};
`endif
    fork
      for (int i = 0; i < 4; i++) begin
        int fl;
        fetch(32'h1000 + 32'(4 * i), fl);
      end
      for (int j = 0; j < 4; j++) data(1, 0, 32'h2000 + 32'(4 * j), 32'd0, 4'd0);
    join
    chk("b2b_count", grants.size(), 32'd8);
    if (grants.size() == 8) begin
      for (int k = 0; k < 8; k++) chk($sformatf("b2b_grant%0d", k), grants[k], exp_b2b[k]);
    end
    chk("b2b_last_load", data_read_value_out, 32'hDEAD9FE7);

    // Read and write both set behaves as a store.
    data(1, 1, 32'h80, 32'hCAFEF00D, 4'b1111);
    chk("rw_is_write", {31'd0, act_we}, 32'd1);
    chk("rw_addr", act_addr, 32'h80);
    chk("rw_keeps_value", data_read_value_out, 32'hDEAD9FE7);

    // Asynchronous reset while a transaction is outstanding.
    lat = 10;
    data_address_in = 32'h600;
    data_read_en_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_valid_out) seen = 1;
    end
    if (!seen) timeout("rst_busy_wait");
    @(posedge clk); #2;
    reset_n = 1'b0;
    data_read_en_in = 1'b0;
    #1;
    chk("rst_valid", {31'd0, mem_valid_out}, 32'd0);
    chk("rst_addr", mem_address_out, 32'd0);
    chk("rst_instr_value", instr_read_value_out, 32'd0);
    chk("rst_data_value", data_read_value_out, 32'd0);
    chk("rst_readies", {30'd0, instr_ready_out, data_ready_out}, 32'd0);
    chk("rst_wr", {27'd0, mem_write_en_out, mem_write_mask_out}, 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("post_rst_idle", {31'd0, mem_valid_out}, 32'd0);
    lat = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32_mem_arbiter.md
# rv32_mem_arbiter

Shares one single-ported, variable-latency memory bus between the instruction-fetch port and the load/store data port of the rv32 pipeline. Requests are accepted, arbitrated, registered onto the memory bus, and completed with a one-cycle ready pulse back to the winning requester. It sits between the fetch and mem stages and the external/shared RAM, and replaces their private memory arrays.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock; all state changes on posedge
- reset_n  in  1  asynchronous, active-low reset
- instr_read_en_in  in  1  fetch request, held until instr_ready_out
- instr_address_in  in  32  fetch byte address
- instr_ready_out  out  1  one-cycle completion pulse for fetch
- instr_read_value_out  out  32  fetched word, held until the next fetch completion
- data_read_en_in  in  1  load request, held until data_ready_out
- data_write_en_in  in  1  store request, held until data_ready_out
- data_address_in  in  32  load/store byte address
- data_write_value_in  in  32  store data
- data_write_mask_in  in  4  store byte enables
- data_ready_out  out  1  one-cycle completion pulse for loads/stores
- data_read_value_out  out  32  load result, held until the next load completion
- mem_valid_out  out  1  bus request, held until mem_ready_in
- mem_write_en_out  out  1  1 = write, 0 = read
- mem_address_out  out  32  word address; bits [1:0] always 0
- mem_write_value_out  out  32  write data
- mem_write_mask_out  out  4  byte enables; 4'b0000 on reads
- mem_ready_in  in  1  bus completion, sampled while mem_valid_out=1
- mem_read_value_in  in  32  read data, valid when mem_ready_in=1

## Operation
- Data request = data_read_en_in | data_write_en_in. If both are set, the request is a write.
- Requesters hold their request and operands stable from assertion until the cycle their ready pulse is high. They may drop or change the request on the following edge.
- States:
  - IDLE: mem_valid_out=0. If any request is pending, pick a winner. On the edge, register the winner's address (bits [1:0] cleared), write flag, write value and mask onto the mem_* outputs. Record the owner, set mem_valid_out=1, go to BUSY.
  - BUSY: hold all mem_* outputs. On the edge with mem_ready_in=1, clear mem_valid_out and set the owner's ready_out=1. Capture mem_read_value_in into the owner's read_value_out for reads only; writes leave data_read_value_out unchanged. Go to RESP.
  - RESP: ready pulse visible. On the next edge, clear ready and go to IDLE. No request is sampled in RESP, so a held request is not re-granted.
- Arbitration (default): when both ports request in IDLE, data wins.
- Reset (asynchronous, any state) sets:
  - state to IDLE;
  - all outputs to 0, including read values;
  - the round-robin pointer (if configured) to "last = instr".
- An in-flight transaction is abandoned on reset. The memory must tolerate mem_valid_out dropping without mem_ready_in.

## Timing
- Request first seen in cycle N → mem_valid_out high from cycle N+1.
- mem_ready_in high in cycle M → ready_out and read_value_out valid in cycle M+1.
- Zero-wait memory: request at N, ready at N+2. The next grant can be sampled at N+3, giving a minimum of 3 cycles per transaction.
- mem_ready_in is ignored outside BUSY.
- Exactly one ready_out pulses per transaction, and never both in the same cycle.

## Configuration
- RV32_MEM_ARB_ROUND_ROBIN_EN defined:
  - adds a one-bit last-grant register, updated on every grant;
  - on a conflict, the port not granted last wins;
  - after reset, the first conflict goes to data.
- Undefined: fixed data priority; no pointer register. Fetch can starve while data requests back-to-back.

## Test plan
- Single fetch, addr 0x0000_0106, zero-wait mem returning 0xDEADBEEF → mem_address_out=0x0000_0104, mem_write_mask_out=0, instr_ready_out pulses 2 cycles after request, instr_read_value_out=0xDEADBEEF and held.
- Store addr 0x40, value 0x12345678, mask 4'b0011, mem_ready_in delayed 3 cycles → mem_* outputs stable for 4 cycles, data_ready_out single pulse, data_read_value_out unchanged.
- Fetch and load asserted in the same cycle, both held:
  - default build → data granted first, fetch second;
  - RR build → data first, then fetch; repeated conflicts alternate.
- Continuous data requests with fetch pending, 4 transactions:
  - default → fetch never granted;
  - RR → fetch granted every second transaction.
- reset_n low while BUSY → all outputs 0 immediately (asynchronous). After release with no requests, mem_valid_out stays 0.
- read_en and write_en both set → mem_write_en_out=1; the request completes as a store.
